// File: rtl/lcd_fifo_if.sv
// Handshake bundle between the command generator (master) and lcd_fifo (slave).
// Carries flush, push/pop requests, data and all status flags; clk/rst stay outside.
interface lcd_fifo_if #(
  parameter int W = 8,
  parameter int N = 16
);
  localparam int CW = $clog2(N) + 1;

  logic          clr;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic          full;
  logic          almost_full;
  logic          rd_en;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  modport master (
    output clr, wr_en, wr_data, rd_en,
    input  full, almost_full, rd_data, rd_valid, empty, count, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, wr_data, rd_en,
    output full, almost_full, rd_data, rd_valid, empty, count, overflow, underflow
  );
endinterface

// File: rtl/lcd_fifo.sv
// Synchronous FIFO buffering LCD command/data words, with exact occupancy and sticky errors.
// Define LCD_FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module lcd_fifo #(
  parameter int W        = 8,
  parameter int N        = 16,
  parameter int AF_LEVEL = N - 2
) (
  input  logic       clk,
  input  logic       rst,
  lcd_fifo_if.slave  bus
);
  localparam int AW = $clog2(N);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] N_C  = CW'(N);
  localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);

  logic [W-1:0]  mem_q [N];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d, af_q, af_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic          rd_acc, wr_acc;

  // clr gates both accepts so a flush cycle neither moves data nor raises flags.
  assign rd_acc = bus.rd_en && !empty_q && !bus.clr;
  assign wr_acc = bus.wr_en && (!full_q || rd_acc) && !bus.clr;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (bus.clr) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (wr_acc) wp_d = wp_q + AW'(1);
      if (rd_acc) rp_d = rp_q + AW'(1);
      count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
      if (bus.wr_en && full_q && !rd_acc) ovf_d = 1'b1;
      if (bus.rd_en && empty_q)           udf_d = 1'b1;
    end
    full_d  = (count_d == N_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
  end

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // NOTE: storage has no reset; occupancy is defined by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wp_q] <= bus.wr_data;
  end

`ifdef LCD_FIFO_FWFT_EN
  assign bus.rd_data  = mem_q[rp_q];
  assign bus.rd_valid = !empty_q;
`else
  logic [W-1:0] rd_data_q, rd_data_d;
  logic         rd_valid_q, rd_valid_d;

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (rd_acc) begin
      rd_data_d  = mem_q[rp_q];
      rd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.full        = full_q;
  assign bus.almost_full = af_q;
  assign bus.empty       = empty_q;
  assign bus.count       = count_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = udf_q;
endmodule
